// File: rtl/pipe_ctrl_unit.sv
// Pipelined main-decoder control: ID decode, ID/EX -> EX/MEM -> MEM/WB bundles, load-use stall,
// branch flush and a multi-cycle multiply FSM. Multiply support is built only when CTRL_MUL_EN is defined.
//
// state | meaning
// IDLE  | no multiply occupying EX beyond its first cycle
// BUSY  | multiply held in ID/EX; counter runs down to the exit cycle
module pipe_ctrl_unit #(
    parameter int OPW        = 6,
    parameter int RW         = 5,
    parameter int OP_RTYPE   = 0,
    parameter int OP_ADDI    = 10,
    parameter int OP_LW      = 35,
    parameter int OP_BEQ     = 2,
    parameter int OP_SW      = 43,
    parameter int OP_MUL     = 28,
    parameter int MUL_CYCLES = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode_id,
    input  logic [RW-1:0]  rs_id,
    input  logic [RW-1:0]  rt_id,
    input  logic           branch_taken,
    output logic           stall_if,
    output logic [10:0]    ex_ctrl,
    output logic [3:0]     mem_ctrl,
    output logic [1:0]     wb_ctrl,
    output logic           illegal_op,
    output logic           mul_busy
);

    localparam int CW = $clog2(MUL_CYCLES);

    localparam int REGWRITE = 10;
    localparam int MEMTOREG = 7;
    localparam int MEMWRITE = 6;
    localparam int MEMREAD  = 5;
    localparam int ISMUL    = 0;

    // {RegWrite,RegDst,Branch,MemToReg,MemWrite,MemRead,ALUop[1:0],ALUsrc[1:0],IsMul}
    localparam logic [10:0] CTRL_RTYPE = 11'b1_1_0_0_0_0_10_00_0;
    localparam logic [10:0] CTRL_ADDI  = 11'b1_0_0_0_0_0_11_01_0;
    localparam logic [10:0] CTRL_LW    = 11'b1_0_0_1_0_1_00_01_0;
    localparam logic [10:0] CTRL_BEQ   = 11'b0_0_1_0_0_0_01_10_0;
    localparam logic [10:0] CTRL_SW    = 11'b0_0_0_0_1_0_00_01_0;

    typedef enum logic {IDLE, BUSY} mul_state_t;

    mul_state_t      state;
    logic [CW-1:0]   cnt;

    logic [10:0]     dec_ctrl;
    logic            dec_illegal;
    logic [10:0]     idex_ctrl;
    logic [RW-1:0]   idex_rt;
    logic [3:0]      exmem_ctrl;
    logic [1:0]      memwb_ctrl;
    logic            illegal_q;

    logic            load_use;
    logic            flush;
    logic            mul_start;
    logic            mul_hold;

    always_comb begin
        dec_ctrl    = '0;
        dec_illegal = 1'b0;
        case (opcode_id)
            OPW'(OP_RTYPE): dec_ctrl = CTRL_RTYPE;
            OPW'(OP_ADDI):  dec_ctrl = CTRL_ADDI;
            OPW'(OP_LW):    dec_ctrl = CTRL_LW;
            OPW'(OP_BEQ):   dec_ctrl = CTRL_BEQ;
            OPW'(OP_SW):    dec_ctrl = CTRL_SW;
`ifdef CTRL_MUL_EN
            OPW'(OP_MUL):   dec_ctrl = CTRL_RTYPE | 11'd1;
`else
            OPW'(OP_MUL):   dec_illegal = 1'b1;
`endif
            default:        dec_illegal = 1'b1;
        endcase
    end

    assign load_use = idex_ctrl[MEMREAD] && (idex_rt != '0) &&
                      ((idex_rt == rs_id) || (idex_rt == rt_id));
    assign flush     = branch_taken && (state != BUSY);
    // The first EX cycle of a multiply already holds, before the FSM has reached BUSY.
    assign mul_start = (state == IDLE) && idex_ctrl[ISMUL] && !branch_taken;
    assign mul_hold  = mul_start || ((state == BUSY) && (cnt != '0));
    assign stall_if  = mul_hold || (load_use && !flush);

`ifdef CTRL_MUL_EN
    localparam logic [CW-1:0] CNT_FIRST = CW'(MUL_CYCLES - 2);
    localparam logic [CW-1:0] CNT_CHAIN = CW'(MUL_CYCLES - 1);

    mul_state_t    state_nxt;
    logic [CW-1:0] cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (mul_start) begin
                    state_nxt = BUSY;
                    cnt_nxt   = CNT_FIRST;
                end
            end
            BUSY: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CW'(1);
                end else if (dec_ctrl[ISMUL]) begin
                    // Back-to-back multiply: its first EX cycle is spent in BUSY, so count one more.
                    cnt_nxt = CNT_CHAIN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
`else
    assign state = IDLE;
    assign cnt   = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_ctrl  <= '0;
            idex_rt    <= '0;
            exmem_ctrl <= '0;
            memwb_ctrl <= '0;
            illegal_q  <= 1'b0;
        end else begin
            if (flush || (!mul_hold && load_use)) begin
                idex_ctrl <= '0;
                idex_rt   <= '0;
            end else if (!mul_hold) begin
                idex_ctrl <= dec_ctrl;
                idex_rt   <= rt_id;
            end
            exmem_ctrl <= mul_hold ? 4'b0000 :
                          {idex_ctrl[REGWRITE], idex_ctrl[MEMTOREG],
                           idex_ctrl[MEMWRITE], idex_ctrl[MEMREAD]};
            memwb_ctrl <= exmem_ctrl[3:2];
            illegal_q  <= dec_illegal;
        end
    end

    assign ex_ctrl    = idex_ctrl;
    assign mem_ctrl   = exmem_ctrl;
    assign wb_ctrl    = memwb_ctrl;
    assign illegal_op = illegal_q;
    assign mul_busy   = (state == BUSY);

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: directed scenarios plus randomized traffic against a stage-level model.
// Multiply scenarios follow CTRL_MUL_EN the same way the design does.
module tb_pipe_ctrl_unit;
    localparam int MC = 4;
    localparam logic [5:0] OP_R = 6'd0, OP_ADDI = 6'd10, OP_LW = 6'd35, OP_BEQ = 6'd2,
                           OP_SW = 6'd43, OP_MUL = 6'd28, OP_BAD = 6'd63;
    localparam logic [10:0] B_R    = 11'b11000010000;
    localparam logic [10:0] B_ADDI = 11'b10000011010;
    localparam logic [10:0] B_LW   = 11'b10010100010;
    localparam logic [10:0] B_BEQ  = 11'b00100001100;
    localparam logic [10:0] B_SW   = 11'b00001000010;
    localparam logic [10:0] B_MUL  = 11'b11000010001;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode_id;
    logic [4:0]  rs_id, rt_id;
    logic        branch_taken;
    logic        stall_if;
    logic [10:0] ex_ctrl;
    logic [3:0]  mem_ctrl;
    logic [1:0]  wb_ctrl;
    logic        illegal_op;
    logic        mul_busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(
        .OPW(6), .RW(5), .OP_RTYPE(0), .OP_ADDI(10), .OP_LW(35), .OP_BEQ(2),
        .OP_SW(43), .OP_MUL(28), .MUL_CYCLES(MC)
    ) dut (
        .clk(clk), .rst(rst), .opcode_id(opcode_id), .rs_id(rs_id), .rt_id(rt_id),
        .branch_taken(branch_taken), .stall_if(stall_if), .ex_ctrl(ex_ctrl),
        .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl), .illegal_op(illegal_op), .mul_busy(mul_busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic bt);
        opcode_id    = op;
        rs_id        = rs;
        rt_id        = rt;
        branch_taken = bt;
    endtask

    // Decode table: {illegal, bundle}
    function automatic logic [11:0] ref_decode(input logic [5:0] op);
        case (op)
            OP_R:    return {1'b0, B_R};
            OP_ADDI: return {1'b0, B_ADDI};
            OP_LW:   return {1'b0, B_LW};
            OP_BEQ:  return {1'b0, B_BEQ};
            OP_SW:   return {1'b0, B_SW};
`ifdef CTRL_MUL_EN
            OP_MUL:  return {1'b0, B_MUL};
`endif
            default: return {1'b1, 11'd0};
        endcase
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        drive(OP_BAD, 5'd0, 5'd0, 1'b0);
        tick;
        tick;
        @(negedge clk);
        n_tests++;
        if ({ex_ctrl, mem_ctrl, wb_ctrl, illegal_op, mul_busy} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_regs: got ex=%b mem=%b wb=%b ill=%b busy=%b want all 0",
                     ex_ctrl, mem_ctrl, wb_ctrl, illegal_op, mul_busy);
        end
        rst = 1'b0;
        drive(OP_R, 5'd0, 5'd0, 1'b0);
        #1;
        n_tests++;
        if (stall_if !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stall: got %b want 0", stall_if);
        end
    endtask

    task automatic test_decode;
        logic [5:0]  ops  [6] = '{OP_R, OP_ADDI, OP_LW, OP_BEQ, OP_SW, OP_BAD};
        logic [10:0] ex_e [6] = '{B_R, B_ADDI, B_LW, B_BEQ, B_SW, 11'd0};
        logic [3:0]  mem_e[6] = '{4'b1000, 4'b1000, 4'b1101, 4'b0000, 4'b0010, 4'b0000};
        logic [1:0]  wb_e [6] = '{2'b10, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00};
        for (int i = 0; i < 6; i++) begin
            drive(ops[i], 5'd0, 5'd0, 1'b0);
            tick;
            @(negedge clk);
            n_tests++;
            if (ex_ctrl !== ex_e[i] || illegal_op !== (i == 5)) begin
                n_fail++;
                $display("FAIL decode[%0d]: got ex=%b ill=%b want ex=%b ill=%b",
                         i, ex_ctrl, illegal_op, ex_e[i], (i == 5));
            end
            if (i >= 1) begin
                n_tests++;
                if (mem_ctrl !== mem_e[i-1]) begin
                    n_fail++;
                    $display("FAIL decode_mem[%0d]: got %b want %b", i - 1, mem_ctrl, mem_e[i-1]);
                end
            end
            if (i >= 2) begin
                n_tests++;
                if (wb_ctrl !== wb_e[i-2]) begin
                    n_fail++;
                    $display("FAIL decode_wb[%0d]: got %b want %b", i - 2, wb_ctrl, wb_e[i-2]);
                end
            end
        end
    endtask

    task automatic test_load_use;
        drive(OP_LW, 5'd0, 5'd5, 1'b0);
        tick;
        drive(OP_R, 5'd5, 5'd1, 1'b0);
        @(negedge clk);
        n_tests++;
        if (stall_if !== 1'b1) begin
            n_fail++;
            $display("FAIL lu_stall: got %b want 1", stall_if);
        end
        tick;
        @(negedge clk);
        n_tests++;
        if (ex_ctrl !== 11'd0 || stall_if !== 1'b0) begin
            n_fail++;
            $display("FAIL lu_bubble: got ex=%b stall=%b want ex=0 stall=0", ex_ctrl, stall_if);
        end
        tick;
        @(negedge clk);
        n_tests++;
        if (ex_ctrl !== B_R) begin
            n_fail++;
            $display("FAIL lu_redecode: got %b want %b", ex_ctrl, B_R);
        end
        drive(OP_LW, 5'd0, 5'd0, 1'b0);
        tick;
        drive(OP_R, 5'd0, 5'd1, 1'b0);
        @(negedge clk);
        n_tests++;
        if (stall_if !== 1'b0) begin
            n_fail++;
            $display("FAIL lu_r0_stall: got %b want 0", stall_if);
        end
        tick;
        @(negedge clk);
        n_tests++;
        if (ex_ctrl !== B_R) begin
            n_fail++;
            $display("FAIL lu_r0_ex: got %b want %b", ex_ctrl, B_R);
        end
    endtask

    task automatic test_flush;
        drive(OP_BEQ, 5'd0, 5'd0, 1'b0);
        tick;
        drive(OP_ADDI, 5'd0, 5'd0, 1'b1);
        @(negedge clk);
        n_tests++;
        if (stall_if !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_stall: got %b want 0", stall_if);
        end
        tick;
        drive(OP_R, 5'd0, 5'd0, 1'b0);
        @(negedge clk);
        n_tests++;
        if (ex_ctrl !== 11'd0) begin
            n_fail++;
            $display("FAIL flush_ex: got %b want 0", ex_ctrl);
        end
        tick;
        @(negedge clk);
        n_tests++;
        if (mem_ctrl !== 4'b0000) begin
            n_fail++;
            $display("FAIL flush_mem: got %b want 0000", mem_ctrl);
        end
        tick;
        @(negedge clk);
        n_tests++;
        if (wb_ctrl !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_wb: got %b want 00", wb_ctrl);
        end
    endtask

`ifdef CTRL_MUL_EN
    task automatic test_mul;
        drive(OP_MUL, 5'd0, 5'd0, 1'b0);
        tick;
        drive(OP_R, 5'd0, 5'd0, 1'b0);
        for (int k = 0; k <= MC; k++) begin
            @(negedge clk);
            n_tests++;
            if (stall_if !== (k <= MC - 2) || mul_busy !== (k >= 1 && k <= MC - 1)) begin
                n_fail++;
                $display("FAIL mul_ctl[k=%0d]: got stall=%b busy=%b want stall=%b busy=%b",
                         k, stall_if, mul_busy, (k <= MC - 2), (k >= 1 && k <= MC - 1));
            end
            if (k >= 1) begin
                n_tests++;
                if (mem_ctrl !== ((k == MC) ? 4'b1000 : 4'b0000)) begin
                    n_fail++;
                    $display("FAIL mul_mem[k=%0d]: got %b want %b", k, mem_ctrl,
                             ((k == MC) ? 4'b1000 : 4'b0000));
                end
            end
            tick;
        end
    endtask

    task automatic test_back_to_back;
        logic e_stall, e_busy;
        logic [3:0] e_mem;
        drive(OP_MUL, 5'd0, 5'd0, 1'b0);
        tick;
        for (int k = 0; k <= 2 * MC; k++) begin
            @(negedge clk);
            e_stall = (k <= MC - 2) || (k >= MC && k <= 2 * MC - 2);
            e_busy  = (k >= 1 && k <= 2 * MC - 1);
            e_mem   = (k == MC || k == 2 * MC) ? 4'b1000 : 4'b0000;
            n_tests++;
            if (stall_if !== e_stall || mul_busy !== e_busy || (k >= 1 && mem_ctrl !== e_mem)) begin
                n_fail++;
                $display("FAIL b2b[k=%0d]: got stall=%b busy=%b mem=%b want stall=%b busy=%b mem=%b",
                         k, stall_if, mul_busy, mem_ctrl, e_stall, e_busy, e_mem);
            end
            tick;
            if (k == MC - 1) drive(OP_R, 5'd0, 5'd0, 1'b0);
        end
    endtask

    task automatic test_mul_reset;
        drive(OP_MUL, 5'd0, 5'd0, 1'b0);
        tick;
        drive(OP_BAD, 5'd0, 5'd0, 1'b0);
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({ex_ctrl, mem_ctrl, wb_ctrl, illegal_op, mul_busy, stall_if} !== 20'd0) begin
            n_fail++;
            $display("FAIL mulrst_all: got ex=%b mem=%b wb=%b ill=%b busy=%b stall=%b want all 0",
                     ex_ctrl, mem_ctrl, wb_ctrl, illegal_op, mul_busy, stall_if);
        end
        for (int j = 0; j < MC + 2; j++) begin
            tick;
            @(negedge clk);
            n_tests++;
            if (mem_ctrl !== 4'b0000 || mul_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL mulrst_after[%0d]: got mem=%b busy=%b want mem=0000 busy=0",
                         j, mem_ctrl, mul_busy);
            end
        end
    endtask
`else
    task automatic test_mul_disabled;
        drive(OP_MUL, 5'd0, 5'd0, 1'b0);
        tick;
        @(negedge clk);
        n_tests++;
        if (illegal_op !== 1'b1 || ex_ctrl !== 11'd0 || mul_busy !== 1'b0 || stall_if !== 1'b0) begin
            n_fail++;
            $display("FAIL nomul_decode: got ill=%b ex=%b busy=%b stall=%b want ill=1 ex=0 busy=0 stall=0",
                     illegal_op, ex_ctrl, mul_busy, stall_if);
        end
        tick;
        @(negedge clk);
        n_tests++;
        if (mem_ctrl !== 4'b0000 || mul_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL nomul_after: got mem=%b busy=%b want mem=0000 busy=0", mem_ctrl, mul_busy);
        end
    endtask
`endif

    // Stage-level model: each pipeline register is a plain variable; a multiply is tracked by its age in EX.
    task automatic test_random(input int ncyc);
        logic [10:0] m_ex;
        logic [4:0]  m_rt;
        logic [3:0]  m_mem;
        logic [1:0]  m_wb;
        logic        m_ill, chain, prev_stall;
        int          age;
        logic [5:0]  op;
        logic [4:0]  rs, rt;
        logic        bt, hold, lu, e_stall, e_busy, leaving;
        logic [11:0] d;
        rst = 1'b1;
        drive(OP_R, 5'd0, 5'd0, 1'b0);
        tick;
        rst = 1'b0;
        m_ex = '0; m_rt = '0; m_mem = '0; m_wb = '0; m_ill = 1'b0;
        chain = 1'b0; prev_stall = 1'b0; age = 0;
        op = OP_R; rs = '0; rt = '0;
        for (int c = 0; c < ncyc; c++) begin
            if (!prev_stall) begin
                case ($urandom_range(0, 7))
                    0: op = OP_R;
                    1: op = OP_ADDI;
                    2, 7: op = OP_LW;
                    3: op = OP_BEQ;
                    4: op = OP_SW;
                    5: op = OP_MUL;
                    default: op = 6'($urandom_range(0, 63));
                endcase
                rs = 5'($urandom_range(0, 3));
                rt = 5'($urandom_range(0, 3));
            end
            bt = m_ex[8] && ($urandom_range(0, 1) == 1);
            drive(op, rs, rt, bt);
            hold    = m_ex[0] && (age < MC - 1);
            lu      = m_ex[5] && (m_rt != 5'd0) && (m_rt == rs || m_rt == rt);
            e_stall = hold || (lu && !bt);
            e_busy  = m_ex[0] && (age >= 1 || chain);
            @(negedge clk);
            n_tests++;
            if ({ex_ctrl, mem_ctrl, wb_ctrl, illegal_op, stall_if, mul_busy} !==
                {m_ex, m_mem, m_wb, m_ill, e_stall, e_busy}) begin
                n_fail++;
                $display("FAIL rand[%0d]: got ex=%b mem=%b wb=%b ill=%b stall=%b busy=%b want ex=%b mem=%b wb=%b ill=%b stall=%b busy=%b",
                         c, ex_ctrl, mem_ctrl, wb_ctrl, illegal_op, stall_if, mul_busy,
                         m_ex, m_mem, m_wb, m_ill, e_stall, e_busy);
            end
            d       = ref_decode(op);
            leaving = m_ex[0] && !hold;
            m_wb    = m_mem[3:2];
            m_mem   = hold ? 4'b0000 : {m_ex[10], m_ex[7], m_ex[6], m_ex[5]};
            m_ill   = d[11];
            chain   = leaving && d[0];
            if (bt) begin
                m_ex = '0; m_rt = '0; age = 0;
            end else if (hold) begin
                age++;
            end else if (lu) begin
                m_ex = '0; m_rt = '0; age = 0;
            end else begin
                m_ex = d[10:0]; m_rt = rt; age = 0;
            end
            prev_stall = e_stall;
            tick;
        end
    endtask

    initial begin
        test_reset;
        test_decode;
        test_load_use;
        test_flush;
`ifdef CTRL_MUL_EN
        test_mul;
        test_back_to_back;
        test_mul_reset;
`else
        test_mul_disabled;
`endif
        test_random(400);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Parametrised, pipelined successor to the combinational main decoder of the 5-stage RISC core. It decodes the ID-stage opcode into the control bundle, carries that bundle through ID/EX, EX/MEM and MEM/WB registers, and detects load-use hazards itself. It also applies branch flushes and runs a multi-cycle multiply FSM that freezes the front end. It sits between the IF/ID register and the datapath stage registers and replaces the external stall input with internally generated hazard control.

## Interface
Parameters:
- OPW, 6, opcode width
- RW, 5, register-address width
- OP_RTYPE, 0, R-type opcode
- OP_ADDI, 10, add-immediate opcode
- OP_LW, 35, load-word opcode
- OP_BEQ, 2, branch opcode
- OP_SW, 43, store-word opcode
- OP_MUL, 28, multiply opcode (R-format)
- MUL_CYCLES, 4, EX occupancy of MUL in cycles (≥2)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- opcode_id  in  OPW  opcode of instruction in ID
- rs_id, rt_id  in  RW  source registers of instruction in ID
- branch_taken  in  1  EX-stage branch resolved taken
- stall_if  out  1  hold PC and IF/ID
- ex_ctrl  out  11  ID/EX bundle {RegWrite,RegDst,Branch,MemToReg,MemWrite,MemRead,ALUop[1:0],ALUsrc[1:0],IsMul}
- mem_ctrl  out  4  EX/MEM bundle {RegWrite,MemToReg,MemWrite,MemRead}
- wb_ctrl  out  2  MEM/WB bundle {RegWrite,MemToReg}
- illegal_op  out  1  registered: unknown opcode decoded in ID last cycle
- mul_busy  out  1  multiply FSM in BUSY

## Operation
- Decode (combinational, ID):
  - R-type: RegDst=1, RegWrite=1, ALUop=10, ALUsrc=00.
  - ADDI: ALUsrc=01, RegWrite=1, ALUop=11.
  - LW: ALUsrc=01, MemRead=1, MemToReg=1, RegWrite=1, ALUop=00.
  - BEQ: ALUsrc=10, Branch=1, ALUop=01.
  - SW: ALUsrc=01, MemWrite=1, RegWrite=0, MemToReg=0, ALUop=00.
  - MUL: as R-type plus IsMul=1.
  - Any other opcode: all-zero bundle and illegal_op=1.
- Load-use hazard: ID/EX MemRead=1 and ID/EX rt (captured from rt_id) equals rs_id or rt_id, with address ≠ 0. Response: stall_if=1, a bubble (all-zero) into ID/EX, and the ID instruction re-decoded next cycle.
- Flush: branch_taken=1 loads a bubble into ID/EX. The ID instruction is discarded; stall_if is not raised by the flush.
- Multiply FSM, states IDLE and BUSY, with a down-counter of width clog2(MUL_CYCLES):
  - IDLE→BUSY when ID/EX IsMul=1; the counter loads MUL_CYCLES-2.
  - In BUSY: ID/EX holds, stall_if=1, and EX/MEM receives bubbles.
  - BUSY→IDLE when the counter reaches 0. In that cycle ID/EX IsMul's bundle passes to EX/MEM and ID/EX loads normally.
- Priority: rst > branch_taken > mul BUSY hold > load-use bubble > normal advance.
- branch_taken during BUSY is ignored; a branch cannot be in EX while a MUL is.

## Timing
- Reset: all bundle registers, illegal_op, mul_busy and the counter clear to 0; FSM goes to IDLE. stall_if=0 combinationally after reset.
- Decode-to-EX latency: 1 cycle. EX→MEM is 1 cycle, or MUL_CYCLES for MUL. MEM→WB is 1 cycle.
- stall_if is combinational from the current registers and ID inputs, and is valid in the same cycle.
- A MUL in EX at cycle t reaches EX/MEM at t+MUL_CYCLES. stall_if is high for cycles t..t+MUL_CYCLES-2.
- Reset asserted while BUSY aborts the multiply. No bundle from it reaches EX/MEM.
- Back-to-back MULs: the second enters ID/EX at the cycle of BUSY→IDLE exit and re-enters BUSY the next cycle with no idle gap.
- Load-use with ID opcode=MUL still stalls exactly one cycle.

## Configuration
- CTRL_MUL_EN defined: MUL opcode, IsMul bit and the multiply FSM are present.
- CTRL_MUL_EN undefined:
  - OP_MUL decodes as illegal: all-zero bundle, illegal_op=1.
  - mul_busy is tied 0 and IsMul is tied 0.
  - No BUSY stalls occur.

## Test plan
- Reset, then OP_RTYPE, ADDI, LW, BEQ, SW, opcode 63 in successive cycles → ex_ctrl matches the decode table one cycle later. The SW bundle has RegWrite=0. illegal_op=1 only for 63.
- LW writing rt=5, followed by R-type with rs_id=5 → stall_if=1 for one cycle, ex_ctrl=0 for that cycle, then R-type bundle. The same sequence with rt=0 gives no stall.
- branch_taken=1 while ADDI is in ID → next ex_ctrl=0, and mem_ctrl later shows no RegWrite from that ADDI.
- MUL with MUL_CYCLES=4 → mul_busy high 3 cycles, stall_if high 3 cycles, mem_ctrl RegWrite=1 at cycle t+4.
- rst asserted on the second BUSY cycle → all outputs 0 next cycle, FSM IDLE, and the MUL bundle never appears on mem_ctrl.
- Build without CTRL_MUL_EN, then opcode 28 → illegal_op=1, ex_ctrl=0, mul_busy stays 0.
